seven_stage_hazard_controller: RTL
==================================

Name: seven_stage_hazard_controller

Overview:
- Tracks in-flight destination registers through the execute, memory_issue, memory_receive and writeback stages of the seven-stage core.
- Compares decode-stage source operands against those stages and drives the per-stage hazard flags and true_data_hazard consumed by the operand bypass muxing.
- Issues load-use stalls and inserts execute bubbles.
- Sits beside decode; owns its own shadow pipeline of destination tags.

Parameters:
- REG_ADDR_W, 5, register address width.
- COUNTER_W, 32, width of the optional performance counters.

Ports:
- clock  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- issue_valid  input  1  decode holds a valid instruction this cycle.
- issue_rd  input  REG_ADDR_W  destination of the decode instruction.
- issue_regwrite  input  1  decode instruction writes issue_rd.
- issue_is_load  input  1  decode instruction is a load.
- rs1_addr  input  REG_ADDR_W  decode source 1.
- rs2_addr  input  REG_ADDR_W  decode source 2.
- rs1_used  input  1  source 1 is read.
- rs2_used  input  1  source 2 is read.
- pipeline_stall  input  1  memory back-pressure; freezes the whole tracker.
- flush  input  1  branch/exception redirect; kills decode and execute.
- rs1_hazard_execute, rs1_hazard_memory_issue, rs1_hazard_memory_receive, rs1_hazard_writeback  output  1 each  rs1 matches that stage.
- rs2_hazard_execute, rs2_hazard_memory_issue, rs2_hazard_memory_receive, rs2_hazard_writeback  output  1 each  rs2 matches that stage.
- true_data_hazard  output  1  load-use hazard; decode must hold.
- issue_accept  output  1  decode instruction enters execute at the next edge.
- perf_load_use_cycles  output  COUNTER_W  present only with the optional feature.
- perf_bypass_events  output  COUNTER_W  present only with the optional feature.

Behaviour:
- Reset: reset is asynchronous and active-low. While reset is low, all four tracker entries (E, MI, MR, WB) are invalid, and every output is 0, counters included. Reset asserted mid-operation discards all in-flight tags immediately.
- Entry format: {valid, rd, is_load}. An entry is valid only if regwrite=1 and rd!=0; writes to x0 are never tracked.
- Match: rsN_hazard_S = issue_valid & rsN_used & (rsN_addr!=0) & S.valid & (S.rd==rsN_addr). Flags are raw and unprioritised; several stages may match at once.
- true_data_hazard = issue_valid & (some used, nonzero source whose youngest matching entry is a load in E or MI).
  - A load in MR or WB is not a true hazard; its data is forwardable.
  - A non-load younger match shadows an older load, so it is not a true hazard.
- issue_accept = issue_valid & ~true_data_hazard & ~flush & ~pipeline_stall.
- Advance (pipeline_stall=0): WB<=MR, MR<=MI, MI<=E. E<=issue tag if issue_accept, else bubble (invalid).
- Hold (pipeline_stall=1): MI, MR and WB hold. E holds unless flush=1, in which case E is cleared.
- flush=1 with pipeline_stall=0: E receives a bubble and MI receives the old E (already committed), so it still shifts.
- Load-use latency: a load at E causes 2 stall cycles for a dependent instruction; a load at MI causes 1. All hazard outputs are combinational from registered entries plus decode inputs; this is zero-cycle latency.
- Back-to-back loads to the same rd: the youngest entry governs.

Optional Feature:
- Macro HAZARD_PERF_COUNTERS_EN.
- Defined: two COUNTER_W saturating counters, which stop at all-ones with no wrap.
  - perf_load_use_cycles increments each cycle true_data_hazard=1.
  - perf_bypass_events increments each cycle issue_accept=1 with any hazard flag set.
  - Both counters clear on reset.
- Undefined: the counters and their perf_* ports are absent; nothing else changes.

Decomposition:
- Shared package: REG_ADDR_W default, the entry struct typedef {valid, rd, is_load}, and stage index constants STG_E=0, STG_MI=1, STG_MR=2, STG_WB=3.
- One natural sub-module, hazard_match_port: instantiated once per source; takes one source address plus the four entries; emits the four stage flags and a load-use bit.

Test Plan:
1. Reset low mid-run with E={1,x5,load} -> E invalid immediately; all outputs 0; the next decode reading x5 sees no hazard.
2. Issue ld x5, then add x6,x5,x1 -> true_data_hazard=1 for 2 cycles with issue_accept=0, then rs1_hazard_memory_receive=1 and issue_accept=1.
3. Issue add x7 at t, then read x7 at t+1, t+2, t+3, t+4 -> hazard flags are execute, memory_issue, memory_receive, writeback respectively; true_data_hazard=0 throughout.
4. Write x0, then read x0 -> all flags 0.
5. pipeline_stall=1 for 3 cycles with a load in E -> entries frozen, true_data_hazard held at 1; flush on cycle 2 -> E cleared and hazard drops the same cycle.
6. HAZARD_PERF_COUNTERS_EN with COUNTER_W=4 and 20 load-use cycles -> perf_load_use_cycles saturates at 15.

Source files
------------

// File: rtl/seven_stage_hazard_controller_pkg.sv
// Shared types and constants for the seven-stage hazard controller's shadow tag pipeline.
package seven_stage_hazard_controller_pkg;

  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int NUM_STAGES         = 4;

  localparam int STG_E  = 0;
  localparam int STG_MI = 1;
  localparam int STG_MR = 2;
  localparam int STG_WB = 3;

  typedef struct packed {
    logic                          valid;
    logic [DEFAULT_REG_ADDR_W-1:0] rd;
    logic                          is_load;
  } entry_t;

  localparam entry_t ENTRY_BUBBLE = '{
    valid:   1'b0,
    rd:      {DEFAULT_REG_ADDR_W{1'b0}},
    is_load: 1'b0
  };

endpackage

// File: rtl/seven_stage_hazard_controller_hazard_match_port.sv
// Compares one decode source operand against the four tracked destination tags
// and reports per-stage matches plus whether the youngest match is an unforwardable load.
module hazard_match_port
  import seven_stage_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                         issue_valid,
  input  logic [REG_ADDR_W-1:0]        src_addr,
  input  logic                         src_used,
  input  entry_t [NUM_STAGES-1:0]      entries,
  output logic [NUM_STAGES-1:0]        stage_hit,
  output logic                         load_use
);

  logic active_s;
  logic found_s;

  assign active_s = issue_valid & src_used & (src_addr != {REG_ADDR_W{1'b0}});

  // Raw per-stage match; the first hit scanning from E is the youngest producer and alone decides load-use.
  always_comb begin
    stage_hit = {NUM_STAGES{1'b0}};
    load_use  = 1'b0;
    found_s   = 1'b0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      stage_hit[s] = active_s & entries[s].valid & (entries[s].rd == src_addr);
      if (stage_hit[s] && !found_s) begin
        found_s  = 1'b1;
        load_use = entries[s].is_load & (s <= STG_MI);
      end else begin
        found_s  = found_s;
      end
    end
  end

endmodule

// File: rtl/seven_stage_hazard_controller.sv
// Load-use hazard tracker and bypass-flag generator for the seven-stage core.
// Optional saturating performance counters are built when HAZARD_PERF_COUNTERS_EN is defined.
module seven_stage_hazard_controller
  import seven_stage_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
`ifdef HAZARD_PERF_COUNTERS_EN
  , parameter int COUNTER_W = 32
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_regwrite,
  input  logic                  issue_is_load,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  pipeline_stall,
  input  logic                  flush,
  output logic                  rs1_hazard_execute,
  output logic                  rs1_hazard_memory_issue,
  output logic                  rs1_hazard_memory_receive,
  output logic                  rs1_hazard_writeback,
  output logic                  rs2_hazard_execute,
  output logic                  rs2_hazard_memory_issue,
  output logic                  rs2_hazard_memory_receive,
  output logic                  rs2_hazard_writeback,
  output logic                  true_data_hazard,
  output logic                  issue_accept
`ifdef HAZARD_PERF_COUNTERS_EN
  , output logic [COUNTER_W-1:0] perf_load_use_cycles
  , output logic [COUNTER_W-1:0] perf_bypass_events
`endif
);

  entry_t [NUM_STAGES-1:0] entries_r;
  entry_t                  issue_tag_s;
  logic [NUM_STAGES-1:0]   rs1_hit_s;
  logic [NUM_STAGES-1:0]   rs2_hit_s;
  logic                    rs1_load_use_s;
  logic                    rs2_load_use_s;
  logic                    hazard_s;
  logic                    accept_s;

  hazard_match_port #(.REG_ADDR_W(REG_ADDR_W)) u_match_rs1 (
    .issue_valid (issue_valid),
    .src_addr    (rs1_addr),
    .src_used    (rs1_used),
    .entries     (entries_r),
    .stage_hit   (rs1_hit_s),
    .load_use    (rs1_load_use_s)
  );

  hazard_match_port #(.REG_ADDR_W(REG_ADDR_W)) u_match_rs2 (
    .issue_valid (issue_valid),
    .src_addr    (rs2_addr),
    .src_used    (rs2_used),
    .entries     (entries_r),
    .stage_hit   (rs2_hit_s),
    .load_use    (rs2_load_use_s)
  );

  // Writes to x0 never produce a valid tag, so x0 can never be reported as a hazard.
  assign issue_tag_s.valid   = issue_regwrite & (issue_rd != {REG_ADDR_W{1'b0}});
  assign issue_tag_s.rd      = issue_rd;
  assign issue_tag_s.is_load = issue_is_load;

  // Gating with reset keeps every output low while the tracker is held in reset.
  assign hazard_s = reset & (rs1_load_use_s | rs2_load_use_s);
  assign accept_s = reset & issue_valid & ~hazard_s & ~flush & ~pipeline_stall;

  assign rs1_hazard_execute        = rs1_hit_s[STG_E];
  assign rs1_hazard_memory_issue   = rs1_hit_s[STG_MI];
  assign rs1_hazard_memory_receive = rs1_hit_s[STG_MR];
  assign rs1_hazard_writeback      = rs1_hit_s[STG_WB];
  assign rs2_hazard_execute        = rs2_hit_s[STG_E];
  assign rs2_hazard_memory_issue   = rs2_hit_s[STG_MI];
  assign rs2_hazard_memory_receive = rs2_hit_s[STG_MR];
  assign rs2_hazard_writeback      = rs2_hit_s[STG_WB];
  assign true_data_hazard          = hazard_s;
  assign issue_accept              = accept_s;

  // Shadow tag pipeline: shifts on advance; on hold only E may be killed by a flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        entries_r[s] <= ENTRY_BUBBLE;
      end
    end else if (!pipeline_stall) begin
      entries_r[STG_WB] <= entries_r[STG_MR];
      entries_r[STG_MR] <= entries_r[STG_MI];
      entries_r[STG_MI] <= entries_r[STG_E];
      entries_r[STG_E]  <= accept_s ? issue_tag_s : ENTRY_BUBBLE;
    end else if (flush) begin
      entries_r[STG_E]  <= ENTRY_BUBBLE;
    end else begin
      entries_r         <= entries_r;
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [COUNTER_W-1:0] load_use_cnt_r;
  logic [COUNTER_W-1:0] bypass_cnt_r;
  logic                 any_flag_s;

  function automatic logic [COUNTER_W-1:0] sat_inc(input logic [COUNTER_W-1:0] value);
    return (&value) ? value : value + {{(COUNTER_W-1){1'b0}}, 1'b1};
  endfunction

  assign any_flag_s = (|rs1_hit_s) | (|rs2_hit_s);

  // Saturating event counters; they stick at all-ones rather than wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_use_cnt_r <= {COUNTER_W{1'b0}};
      bypass_cnt_r   <= {COUNTER_W{1'b0}};
    end else begin
      load_use_cnt_r <= hazard_s ? sat_inc(load_use_cnt_r) : load_use_cnt_r;
      bypass_cnt_r   <= (accept_s & any_flag_s) ? sat_inc(bypass_cnt_r) : bypass_cnt_r;
    end
  end

  assign perf_load_use_cycles = load_use_cnt_r;
  assign perf_bypass_events   = bypass_cnt_r;
`endif

endmodule
